// File: rtl/reorder_pkg.sv
// rtl/reorder_pkg.sv - shared types and depth helper for the reorder bank controller
package reorder_pkg;

   typedef enum logic [1:0] {
      FILL  = 2'd0,
      READY = 2'd1,
      DRAIN = 2'd2
   } bank_state_t;

   typedef enum logic {
      RD_IDLE  = 1'b0,
      RD_DRAIN = 1'b1
   } rd_state_t;

   function automatic int unsigned depth(input int unsigned aw);
      return 32'd1 << aw;
   endfunction

endpackage

// File: rtl/bank_state.sv
// rtl/bank_state.sv - per-bank FILL/READY/DRAIN lifecycle register
module bank_state
   import reorder_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        lock_req,
   input  logic        drain_req,
   input  logic        unlock_req,
   output bank_state_t state,
   output logic        lock
);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= FILL;
      end else begin
         case (state)
            FILL:    if (lock_req) state <= READY;
            // a one-entry bank can finish draining in the cycle it is promoted
            READY:   if (unlock_req) state <= FILL;
                     else if (drain_req) state <= DRAIN;
            DRAIN:   if (unlock_req) state <= FILL;
            default: state <= FILL;
         endcase
      end
   end

   assign lock = (state != FILL);

endmodule

// File: rtl/dbuf_bank_ctrl.sv
// rtl/dbuf_bank_ctrl.sv - double-buffered reorder bank scheduler: fill steering, ordered drain, error checks
module dbuf_bank_ctrl
   import reorder_pkg::*;
#(
   parameter int AW = 10
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_vld,
   output logic          in_rdy,
   output logic          push0,
   output logic          push1,
   input  logic          full0,
   input  logic          full1,
   input  logic          vld0,
   input  logic          vld1,
   input  logic          empty0,
   input  logic          empty1,
   input  logic          out_rdy,
   output logic          out_vld,
   output logic          out_sel,
   output logic          pop0,
   output logic          pop1,
   output logic [1:0]    lock,
   output logic          err
);

   localparam int unsigned DEPTH = depth(AW);
   localparam logic [AW:0] LAST  = (AW+1)'(DEPTH - 1);

   bank_state_t st [2];
   logic [1:0]  lock_req, drain_req, unlock_req;
   logic [1:0]  full_v, vld_v, empty_v;
   logic [1:0]  chk_full, chk_empty;
   logic        wr_sel, rd_ptr;
   logic [AW:0] wr_cnt, rd_cnt;
   logic        wr_fire, wr_done, rd_fire, rd_done;
   logic        out_sel_nxt;
   rd_state_t   rd_state, rd_state_nxt;

   assign full_v  = {full1, full0};
   assign vld_v   = {vld1, vld0};
   assign empty_v = {empty1, empty0};

   assign in_rdy  = (st[wr_sel] == FILL);
   assign wr_fire = in_vld && in_rdy;
   assign push0   = wr_fire && !wr_sel;
   assign push1   = wr_fire && wr_sel;
   assign wr_done = wr_fire && (wr_cnt == LAST);
   assign lock_req = wr_done ? (wr_sel ? 2'b10 : 2'b01) : 2'b00;

   always_comb begin
      rd_state_nxt = rd_state;
      out_sel_nxt  = out_sel;
      drain_req    = 2'b00;
      unlock_req   = 2'b00;
      out_vld      = 1'b0;
      rd_fire      = 1'b0;
      rd_done      = 1'b0;
      case (rd_state)
         RD_IDLE: begin
            if (st[rd_ptr] == READY) begin
               rd_state_nxt      = RD_DRAIN;
               out_sel_nxt       = rd_ptr;
               drain_req[rd_ptr] = 1'b1;
            end
         end
         RD_DRAIN: begin
            out_vld = vld_v[out_sel];
            // a bank handed over while still being locked is promoted here
            if (st[out_sel] == READY) drain_req[out_sel] = 1'b1;
            rd_fire = out_vld && out_rdy;
            if (rd_fire && (rd_cnt == LAST)) begin
               rd_done             = 1'b1;
               unlock_req[out_sel] = 1'b1;
               if ((st[~out_sel] == READY) || lock_req[~out_sel]) begin
                  out_sel_nxt           = ~out_sel;
                  drain_req[~out_sel]   = (st[~out_sel] == READY);
               end else begin
                  rd_state_nxt = RD_IDLE;
               end
            end
         end
         default: rd_state_nxt = RD_IDLE;
      endcase
   end

   assign pop0 = rd_fire && !out_sel;
   assign pop1 = rd_fire && out_sel;

   bank_state u_bank0 (
      .clk        (clk),
      .rst_n      (rst_n),
      .lock_req   (lock_req[0]),
      .drain_req  (drain_req[0]),
      .unlock_req (unlock_req[0]),
      .state      (st[0]),
      .lock       (lock[0])
   );

   bank_state u_bank1 (
      .clk        (clk),
      .rst_n      (rst_n),
      .lock_req   (lock_req[1]),
      .drain_req  (drain_req[1]),
      .unlock_req (unlock_req[1]),
      .state      (st[1]),
      .lock       (lock[1])
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_sel    <= 1'b0;
         wr_cnt    <= '0;
         rd_ptr    <= 1'b0;
         rd_cnt    <= '0;
         rd_state  <= RD_IDLE;
         out_sel   <= 1'b0;
         chk_full  <= 2'b00;
         chk_empty <= 2'b00;
         err       <= 1'b0;
      end else begin
         if (wr_fire) wr_cnt <= wr_done ? '0 : wr_cnt + 1'b1;
         if (wr_done) wr_sel <= ~wr_sel;
         if (rd_fire) rd_cnt <= rd_done ? '0 : rd_cnt + 1'b1;
         if (rd_done) rd_ptr <= ~rd_ptr;
         rd_state  <= rd_state_nxt;
         out_sel   <= out_sel_nxt;
         // bank flags are checked one cycle after each lock / unlock transition
         chk_full  <= lock_req;
         chk_empty <= unlock_req & {st[1] == DRAIN, st[0] == DRAIN};
         err <= err
              | (|({push1, push0} & full_v))
              | (|(chk_full & ~full_v))
              | (|(chk_empty & ~empty_v));
      end
   end

endmodule

// File: doc/dbuf_bank_ctrl.md
# dbuf_bank_ctrl

Bank controller for the double-buffered reorder FIFO. It sequences two reorder banks (bank0, bank1): it steers accepted upstream writes into the bank being filled, and locks a bank once all 2**AW offsets have been written. It then drains locked banks to the downstream port strictly in fill order and unlocks each bank after its last pop. It sits between the interface-1/interface-2 handshakes and the two reorder_fifo instances, replacing ad-hoc lock registers and the separate read/write FSMs with one checked scheduler.

## Interface
- AW, 10, bank address width; bank depth D = 2**AW entries
- clk  in  1  clock
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- in_vld  in  1  upstream data valid
- in_rdy  out  1  controller can accept a write this cycle
- push0 / push1  out  1  write strobe to bank0 / bank1
- full0 / full1  in  1  bank reports all offsets written
- vld0 / vld1  in  1  bank head-of-line data valid
- empty0 / empty1  in  1  bank holds no data
- out_rdy  in  1  downstream ready
- out_vld  out  1  downstream valid (muxed bank vld)
- out_sel  out  1  data mux select: 0 = bank0, 1 = bank1
- pop0 / pop1  out  1  read strobe to bank0 / bank1
- lock  out  2  per-bank locked flag (READY or DRAIN)
- err  out  1  sticky protocol error

## Operation
- Per-bank state: FILL, READY, DRAIN. Reset: both FILL.
- Write side: wr_sel (reset 0) names the fill bank. wr_cnt (AW+1 bits, reset 0) counts pushes into it.
  - in_rdy = (state[wr_sel] == FILL).
  - push_k = in_vld && in_rdy && wr_sel == k.
  - On the push that makes wr_cnt == D: the bank goes to READY, wr_cnt clears, and wr_sel toggles.
  - If the new fill bank is not in FILL, in_rdy stays 0 until it returns to FILL.
- Read side: FSM RD_IDLE / RD_DRAIN. rd_ptr (reset 0) names the next bank to drain. rd_cnt (AW+1 bits, reset 0) counts pops.
  - RD_IDLE, state[rd_ptr] == READY: go to RD_DRAIN next cycle. That bank goes to DRAIN and out_sel takes rd_ptr.
  - RD_DRAIN: out_vld = vld[out_sel]; pop_k = out_vld && out_rdy && out_sel == k. Pops only on a completed handshake.
  - On the pop that makes rd_cnt == D: the bank returns to FILL, rd_cnt clears, and rd_ptr toggles.
    - If the other bank is READY in that same cycle, go directly to RD_DRAIN on it (zero bubble).
    - Otherwise go to RD_IDLE.
- Drain order always equals fill order; bank0 is filled and drained first after reset.
- lock[k] = state[k] != FILL.
- out_vld = 0 in RD_IDLE. out_sel holds its last value in RD_IDLE; its reset value is 0.
- err is set and held until reset when any of these occur:
  - push_k while full_k = 1;
  - a bank enters READY without full_k = 1 on the following cycle;
  - a bank enters FILL from DRAIN without empty_k = 1 on the following cycle.

## Timing
- push/pop/in_rdy/out_vld are combinational from the current state and inputs. All state updates occur on the next edge.
- Write acceptance when not stalled: 1 word/cycle.
- Lock latency: the bank is READY in the cycle after its D-th push.
- Read start latency: first out_vld can assert 2 cycles after the D-th push (READY, then DRAIN), provided the bank reports vld.
- Simultaneous events:
  - The D-th push to one bank and the D-th pop from the other in the same cycle are both honoured.
  - The draining bank becomes FILL and the filling bank becomes READY. Writes continue next cycle into the freed bank.
- Counter width: AW+1 bits so D is representable. There is no wrap-around; a counter clears exactly at D.
- Reset asserted mid-operation: all counters clear, states go to FILL, wr_sel = rd_ptr = out_sel = 0, RD_IDLE, and err = 0. All outputs are 0 except in_rdy = 1 in the first cycle after reset release.

## Structure
- Shared package reorder_pkg holds:
  - enum bank_state_t {FILL, READY, DRAIN};
  - enum rd_state_t {RD_IDLE, RD_DRAIN};
  - function depth(AW) returning 2**AW.
- One sub-module, bank_state, instantiated twice: a per-bank FILL/READY/DRAIN register with lock_req and unlock_req inputs and a lock output.
- Write selection, read FSM, counters and error checking live in dbuf_bank_ctrl.

## Test plan
- AW=2, continuous in_vld, out_rdy=1, ideal bank model:
  - push0 for 4 cycles;
  - lock=01 on cycle 5;
  - push1 for the next 4 cycles;
  - out_vld from cycle 6; pop0 ×4, then pop1 ×4 with no bubble.
- out_rdy=0 throughout: 8 pushes accepted (4 per bank), then in_rdy=0 and lock=11. After out_rdy=1, in_rdy returns the cycle after the 4th pop0, and writes go to bank0.
- out_rdy toggling 1/0 during drain: pop asserts only on out_vld&&out_rdy; rd_cnt reaches 4 after exactly 4 handshakes; no pop while out_rdy=0.
- D-th push to bank1 in the same cycle as the D-th pop from bank0: next cycle lock=10, out_sel=1 with out_vld, in_rdy=1 into bank0.
- Bank model forces full0=1 early and the bench issues a push0, or empty0=0 after the final pop: err=1 the next cycle and stays 1 until rst_n=0.
- rst_n=0 for 1 cycle after 3 pushes to bank1 with bank0 draining: next cycle lock=00, out_vld=0, out_sel=0, in_rdy=1, err=0; the next push goes to bank0.
